// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the ID-stage branch resolution unit and its comparator:
// FSM states, control-flow kinds, condition codes and target/readiness helpers.
package branch_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESOLVE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_BR   = 2'd1,
        KIND_JAL  = 2'd2,
        KIND_JALR = 2'd3
    } kind_e;

    // Condition codes; 3'b000 and 3'b111 are never-taken.
    localparam logic [2:0] CMP_EQ  = 3'b001;
    localparam logic [2:0] CMP_NE  = 3'b010;
    localparam logic [2:0] CMP_LT  = 3'b011;
    localparam logic [2:0] CMP_LTU = 3'b100;
    localparam logic [2:0] CMP_GE  = 3'b101;
    localparam logic [2:0] CMP_GEU = 3'b110;

    function automatic kind_e decode_kind(input logic br, input logic jal, input logic jalr);
        case ({br, jal, jalr})
            3'b100:  return KIND_BR;
            3'b010:  return KIND_JAL;
            3'b001:  return KIND_JALR;
            default: return KIND_NONE;
        endcase
    endfunction

    function automatic logic ops_ready(input kind_e kind, input logic r1, input logic r2);
        case (kind)
            KIND_BR:   return r1 & r2;
            KIND_JALR: return r1;
            KIND_JAL:  return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] calc_target(input kind_e kind, input logic [XLEN-1:0] pc,
                                                    input logic [XLEN-1:0] imm,
                                                    input logic [XLEN-1:0] rs1);
        logic [XLEN-1:0] sum;
        if (kind == KIND_JALR) begin
            sum    = rs1 + imm;
            sum[0] = 1'b0;
        end else begin
            sum = pc + imm;
        end
        return sum;
    endfunction

endpackage

// File: rtl/branch_ctrl_cmp.sv
// cmp_32: 32-bit branch condition evaluator, purely combinational.
module cmp_32
    import branch_ctrl_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_cmp,
    output logic        o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_cmp)
            CMP_EQ:  o_taken = (i_a == i_b);
            CMP_NE:  o_taken = (i_a != i_b);
            CMP_LT:  o_taken = ($signed(i_a) < $signed(i_b));
            CMP_LTU: o_taken = (i_a < i_b);
            CMP_GE:  o_taken = ($signed(i_a) >= $signed(i_b));
            CMP_GEU: o_taken = (i_a >= i_b);
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch/jump resolution: waits for operands, resolves one cycle later,
// issues the fetch redirect or misalignment exception, and keeps branch statistics.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [2:0]       cmp_ctrl,
    input  logic [31:0]      pc_id,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    input  logic             rs1_ready,
    input  logic             rs2_ready,
    input  logic             flush_in,
    output logic             stall_id,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_if,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] br_total,
    output logic [CNT_W-1:0] br_taken
);

    state_e           r_state;
    kind_e            r_kind;
    logic [2:0]       r_cmp;
    logic [31:0]      r_rs1;
    logic [31:0]      r_rs2;
    logic [31:0]      r_target;
    logic [31:0]      r_redirect_pc;
    logic [CNT_W-1:0] r_br_total;
    logic [CNT_W-1:0] r_br_taken;

    kind_e            w_dec_kind;
    kind_e            w_cur_kind;
    logic             w_accept;
    logic             w_ready;
    logic             w_kill;
    logic             w_cmp_taken;
    logic             w_taken;
    logic             w_resolve;
    logic             w_aligned;
    logic             w_redirect;
    logic [31:0]      w_target;

    // While waiting, the stalled ID instruction is still on the inputs, so only
    // its operands and target need re-sampling; the kind was fixed at acceptance.
    assign w_dec_kind = decode_kind(is_branch, is_jal, is_jalr);
    assign w_accept   = id_valid && (w_dec_kind != KIND_NONE);
    assign w_cur_kind = (r_state == ST_WAIT) ? r_kind : w_dec_kind;
    assign w_ready    = ops_ready(w_cur_kind, rs1_ready, rs2_ready);
    assign w_target   = calc_target(w_cur_kind, pc_id, imm, rs1_data);
    assign w_kill     = rst | flush_in;

    cmp_32 u_cmp (
        .i_a    (r_rs1),
        .i_b    (r_rs2),
        .i_cmp  (r_cmp),
        .o_taken(w_cmp_taken)
    );

    assign w_taken    = (r_kind == KIND_JAL) || (r_kind == KIND_JALR) ||
                        ((r_kind == KIND_BR) && w_cmp_taken);
    assign w_resolve  = (r_state == ST_RESOLVE) && !w_kill;
    assign w_aligned  = (r_target[1:0] == 2'b00);
    assign w_redirect = w_resolve && w_taken && w_aligned;

    assign stall_id       = !w_kill && (((r_state == ST_IDLE) && w_accept) || (r_state == ST_WAIT));
    assign redirect_valid = w_redirect;
    assign flush_if       = w_redirect;
    assign misalign_exc   = w_resolve && w_taken && !w_aligned;
    assign redirect_pc    = w_redirect ? r_target : r_redirect_pc;
    assign br_total       = r_br_total;
    assign br_taken       = r_br_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_kind        <= KIND_NONE;
            r_cmp         <= 3'b000;
            r_rs1         <= 32'd0;
            r_rs2         <= 32'd0;
            r_target      <= 32'd0;
            r_redirect_pc <= 32'd0;
            r_br_total    <= '0;
            r_br_taken    <= '0;
        end else if (flush_in) begin
            r_state <= ST_IDLE;
            r_kind  <= KIND_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_kind   <= w_dec_kind;
                        r_cmp    <= cmp_ctrl;
                        r_rs1    <= rs1_data;
                        r_rs2    <= rs2_data;
                        r_target <= w_target;
                        r_state  <= w_ready ? ST_RESOLVE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_rs1    <= rs1_data;
                    r_rs2    <= rs2_data;
                    r_target <= w_target;
                    if (w_ready) begin
                        r_state <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    r_state <= ST_IDLE;
                    r_kind  <= KIND_NONE;
                    if (w_redirect) begin
                        r_redirect_pc <= r_target;
                    end
                    // Statistics cover conditional branches only, saturating.
                    if (r_kind == KIND_BR) begin
                        if (r_br_total != '1) begin
                            r_br_total <= r_br_total + CNT_W'(1);
                        end
                        if (w_cmp_taken && (r_br_taken != '1)) begin
                            r_br_taken <= r_br_taken + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_ctrl;

    localparam int unsigned CW = 4;
    localparam int K_BR   = 0;
    localparam int K_JAL  = 1;
    localparam int K_JALR = 2;
    localparam logic [2:0] C_EQ = 3'b001, C_NE = 3'b010, C_LT = 3'b011;
    localparam logic [2:0] C_LTU = 3'b100, C_GE = 3'b101, C_GEU = 3'b110;

    logic          clk, rst, id_valid, is_branch, is_jal, is_jalr;
    logic [2:0]    cmp_ctrl;
    logic [31:0]   pc_id, imm, rs1_data, rs2_data;
    logic          rs1_ready, rs2_ready, flush_in;
    logic          stall_id, redirect_valid, flush_if, misalign_exc;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] br_total, br_taken;

    typedef struct {
        string       name;
        bit          regs;
        logic        stall;
        logic        rv;
        logic        mis;
        logic [31:0] pc;
        logic [CW-1:0] tot;
        logic [CW-1:0] tkn;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] m_total = '0;
    logic [CW-1:0] m_taken = '0;
    logic [31:0]   m_rpc   = 32'd0;

    branch_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .is_branch(is_branch), .is_jal(is_jal),
        .is_jalr(is_jalr), .cmp_ctrl(cmp_ctrl), .pc_id(pc_id), .imm(imm),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
        .flush_in(flush_in), .stall_id(stall_id), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush_if(flush_if), .misalign_exc(misalign_exc),
        .br_total(br_total), .br_taken(br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=0x%08h required=0x%08h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk(mon_e.name, "stall_id", 32'(stall_id), 32'(mon_e.stall));
            chk(mon_e.name, "redirect_valid", 32'(redirect_valid), 32'(mon_e.rv));
            chk(mon_e.name, "flush_if", 32'(flush_if), 32'(mon_e.rv));
            chk(mon_e.name, "misalign_exc", 32'(misalign_exc), 32'(mon_e.mis));
            if (mon_e.regs) begin
                chk(mon_e.name, "redirect_pc", redirect_pc, mon_e.pc);
                chk(mon_e.name, "br_total", 32'(br_total), 32'(mon_e.tot));
                chk(mon_e.name, "br_taken", 32'(br_taken), 32'(mon_e.tkn));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input bit regs, input logic st, input logic rv,
                        input logic mis, input logic [31:0] pc);
        exp_t e;
        e.name = nm; e.regs = regs; e.stall = st; e.rv = rv; e.mis = mis;
        e.pc = pc; e.tot = m_total; e.tkn = m_taken;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        id_valid = 0; is_branch = 0; is_jal = 0; is_jalr = 0; cmp_ctrl = 3'b000;
        pc_id = 0; imm = 0; rs1_data = 0; rs2_data = 0;
        rs1_ready = 0; rs2_ready = 0; flush_in = 0;
    endtask

    task automatic idle(input string nm);
        clear_inputs();
        push({nm, ":idle"}, 1, 0, 0, 0, m_rpc);
        step();
    endtask

    // Operand not yet ready carries a decoy value so a premature latch would show.
    task automatic set_ops(input int kind, input bit rdy, input logic [31:0] a,
                           input logic [31:0] b);
        rs1_ready = (kind == K_JALR) ? rdy : 1'b1;
        rs2_ready = (kind == K_BR) ? rdy : 1'b1;
        rs1_data  = (kind == K_JALR && !rdy) ? 32'hDEADBEEF : a;
        rs2_data  = (kind == K_BR && !rdy) ? a : b;
    endtask

    task automatic issue(input string nm, input int kind, input logic [2:0] cc,
                         input logic [31:0] pc, input logic [31:0] im,
                         input logic [31:0] a, input logic [31:0] b, input int nwait,
                         input int flush_at, input bit tk, input logic [31:0] tgt);
        logic rv, mis;
        id_valid = 1; is_branch = (kind == K_BR); is_jal = (kind == K_JAL);
        is_jalr = (kind == K_JALR); cmp_ctrl = cc; pc_id = pc; imm = im;
        set_ops(kind, nwait == 0, a, b);
        push({nm, ":accept"}, 1, 1, 0, 0, m_rpc);
        step();
        for (int k = 1; k <= nwait; k++) begin
            set_ops(kind, k == nwait, a, b);
            if (flush_at == 1 && k == 1) begin
                flush_in = 1;
                push({nm, ":wait_flush"}, 1, 0, 0, 0, m_rpc);
                step();
                idle(nm);
                return;
            end
            push({nm, ":wait"}, 1, 1, 0, 0, m_rpc);
            step();
        end
        if (flush_at == 2) begin
            flush_in = 1;
            push({nm, ":resolve_flush"}, 1, 0, 0, 0, m_rpc);
            step();
            idle(nm);
            return;
        end
        rv  = tk && (tgt[1:0] == 2'b00);
        mis = tk && (tgt[1:0] != 2'b00);
        push({nm, ":resolve"}, 1, 0, rv, mis, rv ? tgt : m_rpc);
        step();
        if (kind == K_BR) begin
            if (m_total != '1) m_total = m_total + 1'b1;
            if (tk && m_taken != '1) m_taken = m_taken + 1'b1;
        end
        if (rv) m_rpc = tgt;
        idle(nm);
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        step();
        push("reset", 1, 0, 0, 0, 32'd0);
        step();
        rst = 0;
        idle("post_reset");

        // Non-control, invalid and multi-hot decodes are not accepted
        id_valid = 1;
        push("non_ctrl", 1, 0, 0, 0, m_rpc); step();
        id_valid = 0; is_branch = 1;
        push("no_valid", 1, 0, 0, 0, m_rpc); step();
        id_valid = 1; is_jal = 1;
        push("multi_hot", 1, 0, 0, 0, m_rpc); step();
        idle("decode");

        issue("beq",    K_BR,   C_EQ,  32'h100, 32'h20, 32'd5, 32'd5, 0, 0, 1, 32'h120);
        issue("blt",    K_BR,   C_LT,  32'h200, 32'h40, 32'hFFFFFFFF, 32'd1, 0, 0, 1, 32'h240);
        issue("bltu",   K_BR,   C_LTU, 32'h300, 32'h10, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'h310);
        issue("bne_w3", K_BR,   C_NE,  32'h400, 32'hFFFFFFF0, 32'd7, 32'd9, 3, 0, 1, 32'h3F0);
        issue("jalr_a", K_JALR, 3'b000, 32'h500, 32'h2, 32'h1003, 32'd0, 0, 0, 1, 32'h1004);
        issue("jalr_m", K_JALR, 3'b000, 32'h500, 32'h2, 32'h1001, 32'd0, 0, 0, 1, 32'h1002);
        issue("jal_m",  K_JAL,  3'b000, 32'h0,   32'h6, 32'd0, 32'd0, 0, 0, 1, 32'h6);
        issue("jal_a",  K_JAL,  3'b000, 32'h80,  32'h100, 32'd0, 32'd0, 0, 0, 1, 32'h180);
        issue("bge",    K_BR,   C_GE,  32'h600, 32'h8, 32'd5, 32'hFFFFFFFD, 0, 0, 1, 32'h608);
        issue("bgeu",   K_BR,   C_GEU, 32'h700, 32'h8, 32'd5, 32'hFFFFFFFD, 0, 0, 0, 32'h708);
        issue("beq_ne", K_BR,   C_EQ,  32'h800, 32'h8, 32'd3, 32'd4, 0, 0, 0, 32'h808);
        issue("cc000",  K_BR,   3'b000, 32'h900, 32'h8, 32'd6, 32'd6, 0, 0, 0, 32'h908);
        issue("cc111",  K_BR,   3'b111, 32'hA00, 32'h8, 32'd6, 32'd6, 0, 0, 0, 32'hA08);
        issue("jalr_w", K_JALR, 3'b000, 32'hB00, 32'h10, 32'h2000, 32'd0, 1, 0, 1, 32'h2010);
        issue("fl_wait", K_BR,  C_NE,  32'hC00, 32'h8, 32'd1, 32'd2, 2, 1, 1, 32'hC08);
        issue("fl_res",  K_BR,  C_EQ,  32'hD00, 32'h8, 32'd1, 32'd1, 0, 2, 1, 32'hD08);

        for (int i = 0; i < 20 && m_taken != '1; i++) begin
            issue("fill", K_BR, C_EQ, 32'hE00, 32'h4, 32'd2, 32'd2, 0, 0, 1, 32'hE04);
        end
        issue("sat", K_BR, C_EQ, 32'hF00, 32'h4, 32'd2, 32'd2, 0, 0, 1, 32'hF04);

        // Synchronous reset while waiting on an operand
        id_valid = 1; is_branch = 1; cmp_ctrl = C_EQ; pc_id = 32'h40; imm = 32'h8;
        set_ops(K_BR, 0, 32'd1, 32'd1);
        push("rst_wait:accept", 1, 1, 0, 0, m_rpc); step();
        rst = 1;
        push("rst_wait:rst0", 0, 0, 0, 0, m_rpc); step();
        m_total = '0; m_taken = '0; m_rpc = 32'd0;
        push("rst_wait:rst1", 1, 0, 0, 0, 32'd0); step();
        rst = 0;
        idle("rst_wait");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
